// File: rtl/bin2bcd_seq_ctrl.sv
// bin2bcd_seq_ctrl: sequential shift-and-add-3 (double-dabble) binary-to-BCD
// converter. One add-3 stage is reused over WIDTH cycles.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, binary    : conversion request and operand (captured when ready=1)
//   ready, busy      : idle / converting status, decoded from state (registered)
//   done             : one-cycle pulse when hundreds/tens/ones hold a new result
//   hundreds/tens/ones : registered BCD digits, held until the next completion
module bin2bcd_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] binary,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned SR_W  = BCD_W + WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state, state_n;
  logic [SR_W-1:0]   sreg, sreg_n, sreg_adj, sreg_shl;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ready_n, busy_n, done_n;
  logic [3:0]        hundreds_n, tens_n, ones_n;

  // Add-3 correction on each BCD nibble >= 5, then the combined shift.
  always_comb begin
    sreg_adj = sreg;
    for (int i = 0; i < 3; i++) begin
      if (sreg[WIDTH + 4*i +: 4] >= 4'd5)
        sreg_adj[WIDTH + 4*i +: 4] = sreg[WIDTH + 4*i +: 4] + 4'd3;
    end
    sreg_shl = {sreg_adj[SR_W-2:0], 1'b0};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n    = state;
    sreg_n     = sreg;
    cnt_n      = cnt;
    done_n     = 1'b0;
    hundreds_n = hundreds;
    tens_n     = tens;
    ones_n     = ones;
    unique case (state)
      IDLE: begin
        if (start) begin
          sreg_n  = SR_W'(binary);
          cnt_n   = '0;
          state_n = CONV;
        end
      end
      CONV: begin
        sreg_n = sreg_shl;
        cnt_n  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          hundreds_n = sreg_shl[SR_W-1 -: 4];
          tens_n     = sreg_shl[SR_W-5 -: 4];
          ones_n     = sreg_shl[SR_W-9 -: 4];
          done_n     = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
    busy_n  = (state_n == CONV);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      hundreds <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      cnt      <= cnt_n;
      ready    <= ready_n;
      busy     <= busy_n;
      done     <= done_n;
      hundreds <= hundreds_n;
      tens     <= tens_n;
      ones     <= ones_n;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Self-checking bench for bin2bcd_seq_ctrl: directed scenarios plus a shuffled
// full sweep and randomized traffic, checked against integer division.
module tb_bin2bcd_seq_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] binary;
  logic             ready, busy, done;
  logic [3:0]       hundreds, tens, ones;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  bin2bcd_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
    .ready(ready), .busy(busy), .done(done),
    .hundreds(hundreds), .tens(tens), .ones(ones)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: digits packed as 0xHTO, from plain integer arithmetic.
  function automatic int ref_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic int digits();
    return int'({hundreds, tens, ones});
  endfunction

  // Called at a negedge while ready: request one conversion.
  task automatic accept(input int v);
    start  = 1'b1;
    binary = WIDTH'(v);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("ready_after_accept", int'(ready), 0);
  endtask

  // Waits (bounded) for done; digits must hold the previous result meanwhile.
  task automatic wait_done(output int n, input int hold, input bit noise);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
      check("hold", digits(), hold);
      if (noise) begin
        binary = WIDTH'($urandom);
        start  = 1'($urandom);
      end
    end
    if (!done) check("done_timeout", 0, 1);
    start = 1'b0;
  endtask

  int n, prev, dc0, gap;
  int vals[256];
  int chain[6] = '{100, 120, 186, 222, 255, 0};

  initial begin
    rst_n = 1'b0; start = 1'b0; binary = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_digits", digits(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single conversion of 12
    accept(12);
    wait_done(n, 0, 1'b0);
    check("t1_latency", n, WIDTH);
    check("t1_digits", digits(), ref_bcd(12));
    check("t1_ready_in_done", int'(ready), 1);
    check("t1_busy_in_done", int'(busy), 0);
    prev = ref_bcd(12);

    // 2: back-to-back chain, start asserted in each done cycle
    foreach (chain[i]) begin
      accept(chain[i]);
      wait_done(n, prev, 1'b0);
      check("t2_gap", n + 1, WIDTH + 1);
      check("t2_digits", digits(), ref_bcd(chain[i]));
      prev = ref_bcd(chain[i]);
    end
    @(negedge clk);
    check("t2_done_one_cycle", int'(done), 0);

    // 3: start while busy is ignored
    dc0 = done_cnt;
    accept(200);
    repeat (2) @(negedge clk);
    start = 1'b1; binary = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, prev, 1'b0);
    check("t3_latency", n + 3, WIDTH);
    check("t3_digits", digits(), ref_bcd(200));
    prev = ref_bcd(200);
    repeat (12) @(negedge clk) check("t3_hold", digits(), prev);
    check("t3_done_count", done_cnt - dc0, 1);

    // 4: binary changes after acceptance have no effect
    accept(99);
    binary = 8'd250;
    wait_done(n, prev, 1'b0);
    check("t4_digits", digits(), ref_bcd(99));
    prev = ref_bcd(99);
    @(negedge clk);

    // 5: reset mid-conversion
    accept(173);
    repeat (3) @(negedge clk);
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t5_rst_digits", digits(), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_ready", int'(ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_no_done", done_cnt - dc0, 0);
    check("t5_ready_after", int'(ready), 1);
    check("t5_digits_cleared", digits(), 0);
    accept(173);
    wait_done(n, 0, 1'b0);
    check("t5_digits", digits(), ref_bcd(173));
    prev = ref_bcd(173);

    // 6: shuffled sweep of all 256 values, back-to-back, with input noise
    for (int i = 0; i < 256; i++) vals[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = vals[i]; vals[i] = vals[j]; vals[j] = t;
    end
    dc0 = done_cnt;
    foreach (vals[i]) begin
      accept(vals[i]);
      wait_done(n, prev, 1'b1);
      check("sweep_latency", n, WIDTH);
      check($sformatf("sweep_%0d", vals[i]), digits(), ref_bcd(vals[i]));
      prev = ref_bcd(vals[i]);
    end
    check("sweep_done_count", done_cnt - dc0, 256);

    // Random traffic with idle gaps
    for (int k = 0; k < 40; k++) begin
      int v;
      gap = int'($urandom_range(3, 0));
      repeat (gap) @(negedge clk) check("idle_hold", digits(), prev);
      v = int'($urandom_range(255, 0));
      accept(v);
      wait_done(n, prev, 1'b1);
      check("rand_digits", digits(), ref_bcd(v));
      prev = ref_bcd(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
